// File: rtl/dff_pipe_pkg.sv
// Shared helpers for the dff_pipe register pipeline: occupancy counter sizing.
package dff_pipe_pkg;

  // Width of a counter able to hold 0..depth.
  function automatic int unsigned occ_width(input int unsigned depth);
    return (depth < 32'd1) ? 32'd1 : $clog2(depth + 32'd1);
  endfunction

endpackage

// File: rtl/dff_pipe_stage.sv
// One pipeline stage: a valid/data register pair with synchronous active-low
// reset, flush clear and a load enable driven by the ready chain.
module dff_pipe_stage #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             load,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_r;
  logic [WIDTH-1:0] data_r;

  // Stage state; data only moves when a real word arrives, so bubbles keep old data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_r <= 1'b0;
      data_r  <= RESET_VAL;
    end else if (flush) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= in_valid;
      if (in_valid) begin
        data_r <= in_data;
      end
    end
  end

  assign valid = valid_r;
  assign data  = data_r;

endmodule

// File: rtl/dff_pipe_sync_reset.sv
// Multi-stage register pipeline with valid/ready backpressure, bubble collapse,
// synchronous flush and an occupancy count of valid stages.
module dff_pipe_sync_reset
  import dff_pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = 8,
  parameter int unsigned      DEPTH     = 3,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [WIDTH-1:0]              in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [WIDTH-1:0]              out_data,
  output logic [occ_width(DEPTH)-1:0]   occupancy
);

  localparam int unsigned OCC_W = occ_width(DEPTH);

  typedef struct packed {
    logic             valid;
    logic [WIDTH-1:0] data;
  } stage_t;

  stage_t           stage_s [DEPTH];
  logic [DEPTH-1:0] load_s;
  logic [OCC_W-1:0] occ_s;

  // Ready chain walked from the output side: a stage loads if it is empty or everything ahead moves.
  always_comb begin
    logic rdy_v;
    rdy_v  = out_ready;
    load_s = '0;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      rdy_v     = ~stage_s[i].valid | rdy_v;
      load_s[i] = rdy_v;
    end
  end

  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_stage
    logic             up_valid_s;
    logic [WIDTH-1:0] up_data_s;

    if (i == 0) begin : g_head
      assign up_valid_s = in_valid;
      assign up_data_s  = in_data;
    end else begin : g_body
      assign up_valid_s = stage_s[i-1].valid;
      assign up_data_s  = stage_s[i-1].data;
    end

    dff_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .flush    (flush),
      .load     (load_s[i]),
      .in_valid (up_valid_s),
      .in_data  (up_data_s),
      .valid    (stage_s[i].valid),
      .data     (stage_s[i].data)
    );
  end

  // Popcount of the stage valid bits.
  always_comb begin
    occ_s = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      occ_s = occ_s + OCC_W'(stage_s[i].valid);
    end
  end

  assign in_ready  = load_s[0] & ~flush;
  assign out_valid = stage_s[DEPTH-1].valid & ~flush;
  assign out_data  = stage_s[DEPTH-1].data;
  assign occupancy = occ_s;

endmodule

// File: tb/tb_dff_pipe_sync_reset.sv
// Randomised and directed bench for dff_pipe_sync_reset, checked against a
// word-queue model where each word carries its position in the pipe.
module tb_dff_pipe_sync_reset;

  localparam int unsigned DEPTH = 3;
  localparam logic [7:0]  RV    = 8'hA5;

  logic       clk;
  logic       reset;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] occupancy;

  dff_pipe_sync_reset #(
    .WIDTH     (8),
    .DEPTH     (DEPTH),
    .RESET_VAL (RV)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    int         pos;
  } word_t;

  word_t      q[$];
  word_t      nxt_q[$];
  logic [7:0] last_out;
  int         n_cmp;
  int         n_mis;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Oldest word first: it leaves from the last slot if out_ready, otherwise every
  // word moves forward one slot unless blocked by the word ahead. Returns the
  // lowest slot index taken after the move (DEPTH if the pipe empties).
  function automatic int advance(input bit ordy);
    int lim;
    int np;
    lim = DEPTH;
    nxt_q.delete();
    foreach (q[j]) begin
      if (!(q[j].pos == DEPTH - 1 && ordy)) begin
        np = (q[j].pos + 1 < lim - 1) ? q[j].pos + 1 : lim - 1;
        nxt_q.push_back('{data: q[j].data, pos: np});
        lim = np;
      end
    end
    return lim;
  endfunction

  task automatic step(input bit iv, input logic [7:0] id, input bit ordy,
                      input bit fl, input bit rst);
    int lim;
    bit exp_rdy;
    bit exp_ov;
    bit acc;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    flush     = fl;
    reset     = rst;
    #1;
    lim     = advance(ordy);
    exp_rdy = !fl && (lim >= 1);
    exp_ov  = !fl && (q.size() > 0) && (q[0].pos == DEPTH - 1);
    chk("occupancy", {30'b0, occupancy}, 32'(q.size()));
    chk("out_valid", {31'b0, out_valid}, {31'b0, exp_ov});
    chk("out_data",  {24'b0, out_data},  {24'b0, last_out});
    chk("in_ready",  {31'b0, in_ready},  {31'b0, exp_rdy});
    acc = iv && exp_rdy;
    @(posedge clk);
    if (!rst) begin
      q.delete();
      last_out = RV;
    end else if (fl) begin
      q.delete();
    end else begin
      if (acc) nxt_q.push_back('{data: id, pos: 0});
      q = nxt_q;
      if (q.size() > 0 && q[0].pos == DEPTH - 1) last_out = q[0].data;
    end
    #1;
  endtask

  initial begin
    n_cmp     = 0;
    n_mis     = 0;
    reset     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    last_out = RV;

    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Back-to-back stream with out_ready held high.
    for (int k = 1; k <= 16; k++) step(1'b1, 8'(k), 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Fill under backpressure, then release while still offering a word.
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'h20 + k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h30, 1'b1, 1'b0, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Bubble collapse: A, gap, B while stalled.
    step(1'b1, 8'h41, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h42, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Flush a full pipe with a word offered and downstream ready.
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h50 + k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h5F, 1'b1, 1'b1, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream.
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h60 + k), 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h6F, 1'b1, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Reset together with flush.
    for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h70 + k), 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    // Random traffic with occasional flush and reset.
    for (int k = 0; k < 500; k++) begin
      step(($urandom % 4) != 0, 8'($urandom), ($urandom % 3) != 0,
           ($urandom % 20) == 0, ($urandom % 50) != 0);
    end
    repeat (4) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
